uart_rx_deframer: RTL and testbench

Oversampled UART receive deframer that turns the raw serial input pin into bytes for the debug unit. It sits between the chip's serial RX pin and the debug unit's byte input (`i_rx` / `i_rxDone`), inside the UART. A separate baud generator supplies the 16x oversampling tick. The block synchronises the line, qualifies the start bit, samples each data bit at mid-bit, checks the stop bit, and emits one-cycle done and framing-error pulses.

---
 rtl/uart_rx_deframer.sv | 151 +++++++++++++++
 tb/tb_uart_rx_deframer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// 16x-oversampled UART receive deframer: synchronises the line, qualifies the start bit,
// samples data at mid-bit and checks the stop bit. Define UART_RX_MAJORITY_EN for 2-of-3 sample voting.
module uart_rx_deframer #(
  parameter int NB_DATA = 8,
  parameter int NB_STOP = 16
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rxdone,
  output logic               o_frame_err
);

  localparam int S_W = ($clog2(NB_STOP) > 4) ? $clog2(NB_STOP) : 4;
  localparam int N_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [S_W-1:0] S_MID  = S_W'(7);
  localparam logic [S_W-1:0] S_BIT  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP = S_W'(NB_STOP - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_s_q;
  logic               armed_q, armed_d;
  logic [S_W-1:0]     s_q, s_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               rxdone_q, rxdone_d;
  logic               frame_err_q, frame_err_d;
  logic               sample;

`ifdef UART_RX_MAJORITY_EN
  // The two stored ticks plus the current rx_s form the three-tick voting window.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (i_tick) hist_d = {hist_q[0], rx_s_q};
  end

  always_ff @(posedge clk) begin
    if (i_reset) hist_q <= 2'b11;
    else         hist_q <= hist_d;
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign sample = rx_s_q;
`endif

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    data_d      = data_q;
    rxdone_d    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (s_q == S_MID) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {sample, b_q[NB_DATA-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            // A low stop disarms so a held-low break reports only once.
            if (sample) begin
              data_d   = b_q;
              rxdone_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      rxdone_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      armed_q     <= armed_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      data_q      <= data_d;
      rxdone_q    <= rxdone_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_data      = data_q;
  assign o_rxdone    = rxdone_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: line waveforms are decoded by a sampling-point
// model of the UART frame and compared against the pulses the DUT emits.
module tb_uart_rx_deframer;

  localparam int NB_DATA = 8;
  localparam int NB_STOP = 16;
  localparam int FRAME   = 8 + 16 * NB_DATA + NB_STOP;
  localparam int SYNC    = 2;

  typedef struct {
    int       t;
    bit       err;
    bit [7:0] d;
  } ev_t;

  logic       clk;
  logic       i_reset;
  logic       i_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rxdone;
  logic       o_frame_err;

  int       tests;
  int       failures;
  bit       line[$];
  ev_t      expq[$];
  ev_t      obsq[$];
  bit [7:0] model_last;

  uart_rx_deframer #(.NB_DATA(NB_DATA), .NB_STOP(NB_STOP)) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_tick     (i_tick),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_rxdone   (o_rxdone),
    .o_frame_err(o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic addLevel(input bit v, input int n);
    repeat (n) line.push_back(v);
  endtask

  task automatic addFrame(input bit [7:0] d, input bit stop);
    addLevel(1'b0, 16);
    for (int k = 0; k < NB_DATA; k++) addLevel(d[k], 16);
    addLevel(stop, NB_STOP);
  endtask

  // Value the receiver should see at line index p (one tick per cycle).
  function automatic bit pick(input int p);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(line[p]) + int'(line[p-1]) + int'(line[p-2]);
    return ones >= 2;
`else
    return line[p];
`endif
  endfunction

  function automatic void buildExpected();
    bit       armed;
    int       i;
    int       len;
    bit [7:0] b;
    armed = 1'b0;
    i     = 0;
    len   = line.size();
    b     = '0;
    expq.delete();
    while (i < len) begin
      if (line[i]) begin
        armed = 1'b1;
        i++;
      end else if (!armed) begin
        i++;
      end else if (i + FRAME + 1 + SYNC >= len) begin
        break;
      end else if (line[i+8]) begin
        i += 9;
      end else begin
        for (int k = 0; k < NB_DATA; k++) b[k] = pick(i + 8 + 16 * (k + 1));
        if (pick(i + FRAME)) begin
          model_last = b;
          expq.push_back('{i + FRAME + 1 + SYNC, 1'b0, b});
        end else begin
          armed = 1'b0;
          expq.push_back('{i + FRAME + 1 + SYNC, 1'b1, model_last});
        end
        i += FRAME + 1;
      end
    end
  endfunction

  task automatic doReset();
    i_reset = 1'b1;
    i_rx    = 1'b1;
    i_tick  = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    model_last = '0;
    line.delete();
  endtask

  task automatic applyStimulus();
    bit both;
    both = 1'b0;
    obsq.delete();
    for (int t = 0; t < line.size(); t++) begin
      @(posedge clk);
      #1 i_rx = line[t];
      i_tick = 1'b1;
      @(negedge clk);
      if (o_rxdone && o_frame_err) both = 1'b1;
      if (o_rxdone)    obsq.push_back('{t, 1'b0, o_data});
      if (o_frame_err) obsq.push_back('{t, 1'b1, o_data});
    end
    checkOutput("pulse exclusivity", 32'(both), 32'd0);
  endtask

  task automatic compareEvents(input string tag);
    buildExpected();
    checkOutput($sformatf("%s event count", tag), obsq.size(), expq.size());
    for (int k = 0; k < expq.size() && k < obsq.size(); k++) begin
      checkOutput($sformatf("%s ev%0d kind", tag, k), 32'(obsq[k].err), 32'(expq[k].err));
      checkOutput($sformatf("%s ev%0d time", tag, k), obsq[k].t, expq[k].t);
      checkOutput($sformatf("%s ev%0d data", tag, k), 32'(obsq[k].d), 32'(expq[k].d));
    end
    checkOutput($sformatf("%s final o_data", tag), 32'(o_data), 32'(model_last));
  endtask

  function automatic int obsT(input int k);
    return (k < obsq.size()) ? obsq[k].t : -1;
  endfunction

  function automatic logic [7:0] obsD(input int k);
    return (k < obsq.size()) ? 8'(obsq[k].d) : 8'hxx;
  endfunction

  function automatic int countErr();
    int c;
    c = 0;
    foreach (obsq[k]) if (obsq[k].err) c++;
    return c;
  endfunction

  initial begin
    int       idx;
    int       cyc;
    int       n_done;
    int       n_err;
    bit [7:0] got;
    bit [7:0] rnd;
    tests    = 0;
    failures = 0;

    doReset();
    @(negedge clk);
    checkOutput("reset o_data", 32'(o_data), 32'h0);
    checkOutput("reset o_rxdone", 32'(o_rxdone), 32'h0);
    checkOutput("reset o_frame_err", 32'(o_frame_err), 32'h0);

    // Good frame, latency from rx_s fall to the pulse.
    doReset();
    addLevel(1'b1, 8); addFrame(8'hA5, 1'b1); addLevel(1'b1, 4);
    applyStimulus();
    compareEvents("t1");
    checkOutput("t1 data", 32'(obsD(0)), 32'hA5);
    checkOutput("t1 latency", obsT(0) - 8 - SYNC, 153);

    // Short low pulse must be rejected as a glitch.
    doReset();
    addLevel(1'b1, 8); addLevel(1'b0, 4); addLevel(1'b1, 16);
    addFrame(8'h3C, 1'b1); addLevel(1'b1, 4);
    applyStimulus();
    compareEvents("t2");
    checkOutput("t2 data", 32'(obsD(0)), 32'h3C);

    // Framing error followed by a held-low break.
    doReset();
    addLevel(1'b1, 8); addFrame(8'hA5, 1'b1); addFrame(8'h3C, 1'b0);
    addLevel(1'b0, 200); addLevel(1'b1, 6); addFrame(8'h5A, 1'b1); addLevel(1'b1, 4);
    applyStimulus();
    compareEvents("t3");
    checkOutput("t3 frame errors", countErr(), 1);
    checkOutput("t3 err keeps data", 32'(obsD(1)), 32'hA5);
    checkOutput("t3 data", 32'(o_data), 32'h5A);

    // Reset in the middle of a frame.
    doReset();
    addLevel(1'b1, 8); addFrame(8'hC3, 1'b1); addLevel(1'b1, 6);
    addFrame(8'h5A, 1'b1);
    repeat (FRAME + 8 - 72) void'(line.pop_back());
    applyStimulus();
    compareEvents("t4a");
    @(posedge clk);
    #1 i_reset = 1'b1;
    i_rx = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    checkOutput("t4 reset o_data", 32'(o_data), 32'h0);
    checkOutput("t4 reset o_rxdone", 32'(o_rxdone), 32'h0);
    checkOutput("t4 reset o_frame_err", 32'(o_frame_err), 32'h0);
    model_last = '0;
    line.delete();
    addLevel(1'b1, 8); addFrame(8'h5A, 1'b1); addLevel(1'b1, 4);
    applyStimulus();
    compareEvents("t4b");

    // Back-to-back frames with no idle between stop and start.
    doReset();
    addLevel(1'b1, 8); addFrame(8'h00, 1'b1); addFrame(8'hFF, 1'b1); addLevel(1'b1, 4);
    applyStimulus();
    compareEvents("t5");
    checkOutput("t5 spacing", obsT(1) - obsT(0), 160);
    checkOutput("t5 second data", 32'(obsD(1)), 32'hFF);

    // One-tick high glitch at the sampling point of bit 2.
    doReset();
    addLevel(1'b1, 8); addFrame(8'h00, 1'b1); addLevel(1'b1, 4);
    line[8 + 8 + 16 * 3] = 1'b1;
    applyStimulus();
    compareEvents("t6");
`ifdef UART_RX_MAJORITY_EN
    checkOutput("t6 data", 32'(obsD(0)), 32'h00);
`else
    checkOutput("t6 data", 32'(obsD(0)), 32'h04);
`endif

    // Random frames, gaps and stop levels.
    for (int r = 0; r < 4; r++) begin
      doReset();
      addLevel(1'b1, 8);
      for (int f = 0; f < 5; f++) begin
        rnd = 8'($urandom);
        addFrame(rnd, $urandom_range(0, 3) != 0);
        addLevel(1'b1, $urandom_range(0, 12));
      end
      addLevel(1'b1, 8);
      applyStimulus();
      compareEvents($sformatf("rand%0d", r));
    end

    // Sparse, irregular ticks must only stretch the frame.
    doReset();
    rnd = 8'($urandom);
    addLevel(1'b1, 20); addFrame(rnd, 1'b1); addLevel(1'b1, 20);
    idx = 0; cyc = 0; n_done = 0; n_err = 0; got = '0;
    while (idx < line.size() && cyc < 8000) begin
      @(posedge clk);
      #1 i_rx = line[idx];
      i_tick = ($urandom_range(0, 3) == 0);
      if (i_tick) idx++;
      @(negedge clk);
      if (o_rxdone) begin
        n_done++;
        got = o_data;
      end
      if (o_frame_err) n_err++;
      cyc++;
    end
    i_tick = 1'b1;
    checkOutput("gap budget", 32'(idx >= line.size()), 32'd1);
    checkOutput("gap rxdone count", n_done, 1);
    checkOutput("gap frame_err count", n_err, 0);
    checkOutput("gap data", 32'(got), 32'(rnd));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
